// File: rtl/black_box_pkg.sv
// ============================================================================
// black_box_pkg : shared stage record and count-width helper for the delay line
// Rev 1.0
// ============================================================================
`default_nettype none

// A stage record is {valid, data}; WIDTH varies per instance, hence a macro.
`ifndef BB_STAGE_T
`define BB_STAGE_T(W) struct packed { logic valid; logic [(W)-1:0] data; }
`endif

package black_box_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/black_box_delay_stage.sv
// ============================================================================
// black_box_delay_stage : one valid/data stage with load enable and flush
// Rev 1.0
// ============================================================================
`default_nettype none

module black_box_delay_stage #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           load,
  input  logic           flush,
  input  logic [WIDTH:0] d,
  output logic [WIDTH:0] q
);

  typedef `BB_STAGE_T(WIDTH) stage_t;

  stage_t cur;
  stage_t nxt;

  assign nxt = d;
  assign q   = cur;

  // Data of an invalid beat is left untouched so bubbles cost no toggling.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur.valid <= 1'b0;
      cur.data  <= RESET_VALUE;
    end else if (flush) begin
      cur.valid <= 1'b0;
    end else if (load) begin
      cur.valid <= nxt.valid;
      if (nxt.valid) begin
        cur.data <= nxt.data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/black_box_delay_line.sv
// ============================================================================
// black_box_delay_line : valid-tracked DEPTH-stage delay line with invert,
// stall, flush and occupancy count.  Rev 1.0
// ============================================================================
`default_nettype none

module black_box_delay_line
  import black_box_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_bits,
  input  logic                         in_invert,
  output logic                         in_ready,
  input  logic                         stall,
  input  logic                         flush,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_bits,
  output logic [cnt_width(DEPTH)-1:0]  count
);

  localparam int CW = cnt_width(DEPTH);

  typedef `BB_STAGE_T(WIDTH) stage_t;

  stage_t        chain [DEPTH+1];
  logic          advance;
  logic [CW-1:0] count_r;

  assign advance  = !stall && !flush;
  assign in_ready = !stall;

  assign chain[0] = '{valid: in_valid, data: (in_invert ? ~in_bits : in_bits)};

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    black_box_delay_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clock (clock),
      .reset (reset),
      .load  (advance),
      .flush (flush),
      .d     (chain[k]),
      .q     (chain[k+1])
    );
  end

  assign out_valid = chain[DEPTH].valid;
  assign out_bits  = chain[DEPTH].data;

  // Output beat is always consumed on an advancing edge, so it leaves the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (flush) begin
      count_r <= '0;
    end else if (!stall) begin
      count_r <= count_r + CW'(in_valid) - CW'(out_valid);
    end
  end

  assign count = count_r;

  always @(posedge clock) begin
    if (!reset) begin
      assert (count_r <= CW'(DEPTH));
      assert (!(out_valid && (count_r == '0)));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_black_box_delay_line.sv
// ============================================================================
// tb_black_box_delay_line : scoreboard bench for black_box_delay_line
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_black_box_delay_line;

  localparam int N = 5;
  localparam int DEP [N] = '{4, 1, 2, 7, 7};
  localparam int WID [N] = '{8, 1, 32, 32, 1};
  localparam logic [31:0] RVS [N] = '{32'h0, 32'h1, 32'h12345678, 32'hDEADBEEF, 32'h0};

  typedef struct {
    logic [31:0] data;
    int          age;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_bits = '0;
  logic        in_invert = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;

  logic [N-1:0] ov;
  logic [N-1:0] rdy;
  logic [31:0]  obx [N];
  logic [31:0]  cnx [N];

  logic [7:0]  ob0;  logic [2:0] cn0;
  logic [0:0]  ob1;  logic [0:0] cn1;
  logic [31:0] ob2;  logic [1:0] cn2;
  logic [31:0] ob3;  logic [2:0] cn3;
  logic [0:0]  ob4;  logic [2:0] cn4;

  beat_t sb [N][$];
  int    n_cmp = 0;
  int    n_bad = 0;

  always #5 clock = ~clock;

  black_box_delay_line #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h00)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_bits(in_bits[7:0]),
    .in_invert(in_invert), .in_ready(rdy[0]), .stall(stall), .flush(flush),
    .out_valid(ov[0]), .out_bits(ob0), .count(cn0));

  black_box_delay_line #(.WIDTH(1), .DEPTH(1), .RESET_VALUE(1'b1)) dut_d1_w1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_bits(in_bits[0:0]),
    .in_invert(in_invert), .in_ready(rdy[1]), .stall(stall), .flush(flush),
    .out_valid(ov[1]), .out_bits(ob1), .count(cn1));

  black_box_delay_line #(.WIDTH(32), .DEPTH(2), .RESET_VALUE(32'h12345678)) dut_d2_w32 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_bits(in_bits),
    .in_invert(in_invert), .in_ready(rdy[2]), .stall(stall), .flush(flush),
    .out_valid(ov[2]), .out_bits(ob2), .count(cn2));

  black_box_delay_line #(.WIDTH(32), .DEPTH(7), .RESET_VALUE(32'hDEADBEEF)) dut_d7_w32 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_bits(in_bits),
    .in_invert(in_invert), .in_ready(rdy[3]), .stall(stall), .flush(flush),
    .out_valid(ov[3]), .out_bits(ob3), .count(cn3));

  black_box_delay_line #(.WIDTH(1), .DEPTH(7), .RESET_VALUE(1'b0)) dut_d7_w1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_bits(in_bits[0:0]),
    .in_invert(in_invert), .in_ready(rdy[4]), .stall(stall), .flush(flush),
    .out_valid(ov[4]), .out_bits(ob4), .count(cn4));

  assign obx[0] = 32'(ob0);  assign cnx[0] = 32'(cn0);
  assign obx[1] = 32'(ob1);  assign cnx[1] = 32'(cn1);
  assign obx[2] = ob2;       assign cnx[2] = 32'(cn2);
  assign obx[3] = ob3;       assign cnx[3] = 32'(cn3);
  assign obx[4] = 32'(ob4);  assign cnx[4] = 32'(cn4);

  function automatic logic [31:0] mask_of(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic model_valid(input int i);
    return (sb[i].size() > 0) && (sb[i][0].age == DEP[i]);
  endfunction

  function automatic logic [31:0] model_data(input int i);
    return (sb[i].size() > 0) ? sb[i][0].data : 32'h0;
  endfunction

  // Advance the reference model with the current inputs, then take one edge.
  task automatic tick();
    for (int i = 0; i < N; i++) begin
      if (reset || flush) begin
        sb[i].delete();
      end else if (!stall) begin
        int n;
        n = sb[i].size();
        for (int j = 0; j < n; j++) begin
          beat_t b;
          b = sb[i].pop_front();
          b.age++;
          if (b.age <= DEP[i]) sb[i].push_back(b);
        end
        if (in_valid) begin
          beat_t nb;
          nb.data = (in_invert ? ~in_bits : in_bits) & mask_of(WID[i]);
          nb.age  = 1;
          sb[i].push_back(nb);
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_bits = '0; in_invert = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (ov[i] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", i, ov[i]); end
      n_cmp++;
      if (cnx[i] !== 32'd0) begin n_bad++; $display("FAIL reset_count[%0d]: got %0d expected 0", i, cnx[i]); end
      n_cmp++;
      if (obx[i] !== RVS[i]) begin n_bad++; $display("FAIL reset_out_bits[%0d]: got %h expected %h", i, obx[i], RVS[i]); end
    end
    stall = 1'b1;
    #1;
    n_cmp++;
    if (rdy[0] !== 1'b0) begin n_bad++; $display("FAIL reset_ready_stall: got %b expected 0", rdy[0]); end
    stall = 1'b0;
    #1;
    n_cmp++;
    if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", rdy[0]); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    for (int e = 0; e < 5; e++) begin
      in_valid  = (e == 0);
      in_bits   = 32'h5A;
      in_invert = 1'b0;
      tick();
      n_cmp++;
      if (ov[0] !== (e == 3)) begin n_bad++; $display("FAIL latency_valid e%0d: got %b expected %b", e, ov[0], (e == 3)); end
      n_cmp++;
      if (ob0 !== ((e >= 3) ? 8'h5A : 8'h00)) begin
        n_bad++; $display("FAIL latency_bits e%0d: got %h expected %h", e, ob0, ((e >= 3) ? 8'h5A : 8'h00));
      end
    end
    idle_inputs();
  endtask

  task automatic test_invert();
    int peak = 0;
    for (int e = 0; e < 7; e++) begin
      in_valid  = (e < 2);
      in_bits   = 32'h0F;
      in_invert = (e == 0);
      tick();
      if (int'(cn0) > peak) peak = int'(cn0);
      n_cmp++;
      if (ov[0] !== model_valid(0)) begin n_bad++; $display("FAIL invert_valid e%0d: got %b expected %b", e, ov[0], model_valid(0)); end
      if (model_valid(0)) begin
        n_cmp++;
        if (obx[0] !== model_data(0)) begin n_bad++; $display("FAIL invert_bits e%0d: got %h expected %h", e, obx[0], model_data(0)); end
      end
      if (e == 3 || e == 4) begin
        n_cmp++;
        if (ob0 !== ((e == 3) ? 8'hF0 : 8'h0F)) begin
          n_bad++; $display("FAIL invert_order e%0d: got %h expected %h", e, ob0, ((e == 3) ? 8'hF0 : 8'h0F));
        end
      end
    end
    n_cmp++;
    if (peak != 2) begin n_bad++; $display("FAIL invert_peak_count: got %0d expected 2", peak); end
    idle_inputs();
  endtask

  task automatic test_stall();
    logic [7:0] exp_b;
    for (int e = 0; e < 10; e++) begin
      in_valid = (e <= 5);
      in_bits  = (e == 0) ? 32'd1 : (e == 1) ? 32'd2 : 32'd3;
      stall    = (e >= 2 && e <= 4);
      tick();
      if (stall) begin
        n_cmp++;
        if (cn0 !== 3'd2) begin n_bad++; $display("FAIL stall_count e%0d: got %0d expected 2", e, cn0); end
        n_cmp++;
        if (ov[0] !== 1'b0) begin n_bad++; $display("FAIL stall_valid e%0d: got %b expected 0", e, ov[0]); end
        n_cmp++;
        if (rdy[0] !== 1'b0) begin n_bad++; $display("FAIL stall_ready e%0d: got %b expected 0", e, rdy[0]); end
      end
      exp_b = (e == 6) ? 8'd1 : (e == 7) ? 8'd2 : 8'd3;
      n_cmp++;
      if (ov[0] !== (e >= 6 && e <= 8)) begin
        n_bad++; $display("FAIL stall_out_valid e%0d: got %b expected %b", e, ov[0], (e >= 6 && e <= 8));
      end
      if (e >= 6 && e <= 8) begin
        n_cmp++;
        if (ob0 !== exp_b) begin n_bad++; $display("FAIL stall_out_bits e%0d: got %h expected %h", e, ob0, exp_b); end
      end
      n_cmp++;
      if (cnx[0] !== 32'(sb[0].size())) begin n_bad++; $display("FAIL stall_model_count e%0d: got %0d expected %0d", e, cnx[0], sb[0].size()); end
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    for (int e = 0; e < 4; e++) begin
      in_valid = 1'b1;
      in_bits  = 32'h11 * (e + 1);
      tick();
    end
    n_cmp++;
    if (cn0 !== 3'd4) begin n_bad++; $display("FAIL flush_full_count: got %0d expected 4", cn0); end
    flush = 1'b1; stall = 1'b1; in_valid = 1'b1; in_bits = 32'hAA;
    tick();
    n_cmp++;
    if (cn0 !== 3'd0) begin n_bad++; $display("FAIL flush_count: got %0d expected 0", cn0); end
    n_cmp++;
    if (ov[0] !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b expected 0", ov[0]); end
    idle_inputs();
    for (int e = 0; e < 6; e++) begin
      tick();
      n_cmp++;
      if (ov[0] !== 1'b0) begin n_bad++; $display("FAIL flush_discard e%0d: got valid %b bits %h expected 0", e, ov[0], ob0); end
    end
  endtask

  task automatic test_async_reset();
    for (int e = 0; e < 3; e++) begin
      in_valid = 1'b1;
      in_bits  = 32'hC0 + e;
      tick();
    end
    idle_inputs();
    n_cmp++;
    if (cn0 !== 3'd3) begin n_bad++; $display("FAIL areset_pre_count: got %0d expected 3", cn0); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (ov[0] !== 1'b0) begin n_bad++; $display("FAIL areset_valid: got %b expected 0", ov[0]); end
    n_cmp++;
    if (cn0 !== 3'd0) begin n_bad++; $display("FAIL areset_count: got %0d expected 0", cn0); end
    n_cmp++;
    if (ob0 !== 8'h00) begin n_bad++; $display("FAIL areset_bits: got %h expected 00", ob0); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_param_sweep();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
    tick();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_bits   = $urandom;
      in_invert = $urandom_range(0, 1) == 1;
      stall     = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      tick();
      for (int i = 0; i < N; i++) begin
        n_cmp++;
        if (ov[i] !== model_valid(i)) begin
          n_bad++; $display("FAIL sweep_valid[%0d] c%0d: got %b expected %b", i, c, ov[i], model_valid(i));
        end
        n_cmp++;
        if (cnx[i] !== 32'(sb[i].size())) begin
          n_bad++; $display("FAIL sweep_count[%0d] c%0d: got %0d expected %0d", i, c, cnx[i], sb[i].size());
        end
        if (model_valid(i)) begin
          n_cmp++;
          if (obx[i] !== model_data(i)) begin
            n_bad++; $display("FAIL sweep_bits[%0d] c%0d: got %h expected %h", i, c, obx[i], model_data(i));
          end
        end
        n_cmp++;
        if (rdy[i] !== !stall) begin
          n_bad++; $display("FAIL sweep_ready[%0d] c%0d: got %b expected %b", i, c, rdy[i], !stall);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_invert();
    test_stall();
    test_flush();
    test_async_reset();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/black_box_delay_line.md
# black_box_delay_line

Parametrised, valid-tracked delay line for the black-box test suite. It generalises the single-bit register, passthrough and inverter black boxes into one block with these features:
- configurable width and depth;
- a per-beat invert mode;
- a global stall and a synchronous flush;
- an occupancy count.

Test harnesses instantiate it behind a black-box wrapper to exercise multi-cycle latency, back-pressure and parameter elaboration.

## Interface
Parameters:
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, number of pipeline stages, equal to the latency in cycles (≥1)
- RESET_VALUE, 0, value loaded into every data register on reset (WIDTH bits)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  input beat present
- in_bits  in  WIDTH  input data
- in_invert  in  1  per-beat mode: 1 stores ~in_bits, 0 stores in_bits
- in_ready  out  1  beat accepted this cycle when in_valid && in_ready
- stall  in  1  freeze all stages
- flush  in  1  synchronously invalidate all stages
- out_valid  out  1  output stage holds a valid beat
- out_bits  out  WIDTH  output stage data
- count  out  $clog2(DEPTH+1)  number of valid stages (0..DEPTH)

## Operation
- The pipeline has DEPTH stages, each holding a valid bit and WIDTH data bits. Stage 0 is the input side; stage DEPTH-1 drives out_valid/out_bits.
- advance = !stall && !flush. in_ready = !stall (combinational).
- On advance:
  - stage0.valid <= in_valid.
  - stage0.data <= in_invert ? ~in_bits : in_bits, loaded only when in_valid.
  - Each stage k>0 takes stage k-1. Data registers of invalid beats are don't-care but must not be X after reset.
- During stall without flush: every valid bit, data register and count holds. An input beat is not accepted (in_ready=0), so it is not lost.
- On flush:
  - All valid bits go to 0 and count goes to 0 on the next edge, regardless of stall or in_valid.
  - A beat presented in the flush cycle is discarded.
  - Data registers may keep their values.
- count update:
  - On advance: count_next = count + (in_valid ? 1 : 0) − (out_valid ? 1 : 0).
  - On stall: count holds.
  - On flush: count goes to 0.
  - count never exceeds DEPTH and never underflows. An assertion in simulation checks this.
- The block has no downstream back-pressure. A valid output beat is consumed on every advancing edge.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by the environment):
  - out_valid=0, count=0;
  - all data registers = RESET_VALUE, so out_bits=RESET_VALUE;
  - in_ready follows stall immediately.
- Latency: a beat accepted at edge N appears on out_valid/out_bits after edge N+DEPTH−1. It is visible for the whole cycle following that edge and is consumed at edge N+DEPTH, provided no stall cycles intervene. Each stall cycle adds exactly one cycle.
- Throughput: one beat per cycle when not stalled.
- Simultaneous events:
  - flush and stall together: flush wins.
  - in_valid and out_valid on the same advancing edge: count is unchanged.
- Reset mid-operation clears everything within the same cycle (asynchronous). There is no partial-state recovery.
- DEPTH=1: out_bits is a single registered, optionally inverted copy of the input, with valid.

## Structure
- Package black_box_pkg holds:
  - a typedef for the stage record (valid, data), parametrised via a WIDTH-generic struct or a macro per team practice;
  - the count-width function cnt_width(depth) = $clog2(depth+1).
- Sub-module black_box_delay_stage implements one stage: valid/data flops, a load enable and a flush. It is instantiated DEPTH times in a generate loop. The top level holds the invert mux, the count logic and the ready logic.

## Test plan
- Reset and latency: reset high 2 cycles, then WIDTH=8, DEPTH=4, drive 0x5A valid at edge 0 with invert=0 and no stall → out_valid=1, out_bits=0x5A after edge 3; before that, out_bits=RESET_VALUE (0x00) and out_valid=0.
- Invert mode: send 0x0F with invert=1, then 0x0F with invert=0, back to back → outputs 0xF0 then 0x0F on consecutive cycles; count peaks at 2.
- Stall: stream 1,2,3; assert stall for 3 cycles while the pipe holds 2 beats → count, out_bits and out_valid frozen, in_ready=0; on release the beats emerge in order with latency extended by 3.
- Flush with collision: pipe full (count=4), assert flush together with stall and in_valid=1 (0xAA) → next cycle count=0, out_valid=0; 0xAA never appears.
- Asynchronous reset mid-stream: assert reset between edges with count=3 → out_valid=0, count=0 and out_bits=RESET_VALUE immediately, before the next edge.
- Parameter sweep: DEPTH∈{1,2,7}, WIDTH∈{1,32} with random valid/stall/flush against a reference queue model → bit-exact output order and count at every cycle.
